// File: rtl/pixel_frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_pkg
//  Purpose  : Shared sequencer state encoding and default phase lengths.
//  Revision : 1.0 - initial release
// ============================================================================
package pixel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_READ    = 3'd4,
        ST_WAIT    = 3'd5
    } state_t;

    localparam int unsigned DEF_H         = 4;
    localparam int unsigned DEF_W         = 4;
    localparam int unsigned DEF_C_ERASE   = 5;
    localparam int unsigned DEF_C_EXPOSE  = 255;
    localparam int unsigned DEF_C_CONVERT = 255;
    localparam int unsigned DEF_C_READ    = 5;

    // Counter value seen on the final cycle of a phase lasting 'len' cycles.
    function automatic logic [7:0] last_cycle(input int unsigned len);
        return 8'(len - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_frame_sequencer_if
//  Purpose  : Row output stream (valid/ready, pixel data, row index).
//  Revision : 1.0 - initial release
// ============================================================================
interface pixel_frame_sequencer_if #(
    parameter int unsigned H = 4,
    parameter int unsigned W = 4
);
    localparam int unsigned ROW_W = (H > 1) ? $clog2(H) : 1;

    logic               out_valid;
    logic               out_ready;
    logic [8*W-1:0]     out_data;
    logic [ROW_W-1:0]   out_row;

    modport master (output out_valid, output out_data, output out_row, input out_ready);
    modport slave  (input out_valid, input out_data, input out_row, output out_ready);
endinterface
`default_nettype wire

// File: rtl/pixel_frame_sequencer_row_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_row_buffer
//  Purpose  : Holds one captured row and presents it on a valid/ready stream.
//             Data and row index stay frozen until the consumer accepts.
//  Revision : 1.0 - initial release
// ============================================================================
module pixel_row_buffer #(
    parameter int unsigned H = 4,
    parameter int unsigned W = 4,
    localparam int unsigned ROW_W = (H > 1) ? $clog2(H) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_i,
    input  logic [8*W-1:0]          data_i,
    input  logic [ROW_W-1:0]        row_i,
    output logic                    accept_o,
    pixel_frame_sequencer_if.master out_if
);

    logic               valid_q;
    logic [8*W-1:0]     data_q;
    logic [ROW_W-1:0]   row_q;

    // Capture on load, drop valid once the consumer takes the row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            row_q   <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            row_q   <= row_i;
        end else if (valid_q && out_if.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign accept_o         = valid_q && out_if.out_ready;
    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_row   = row_q;

endmodule
`default_nettype wire

// File: rtl/pixel_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_frame_sequencer
//  Purpose  : Drives erase/expose/convert phases of a pixel array, then reads
//             each row out through a valid/ready row buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module pixel_frame_sequencer
    import pixel_pkg::*;
#(
    parameter int unsigned H         = DEF_H,
    parameter int unsigned W         = DEF_W,
    parameter int unsigned C_ERASE   = DEF_C_ERASE,
    parameter int unsigned C_EXPOSE  = DEF_C_EXPOSE,
    parameter int unsigned C_CONVERT = DEF_C_CONVERT,
    parameter int unsigned C_READ    = DEF_C_READ,
    localparam int unsigned ROW_W    = (H > 1) ? $clog2(H) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    continuous,
    output logic                    erase,
    output logic                    expose,
    output logic                    convert,
    output logic [7:0]              ramp_count,
    output logic [H-1:0]            read_en,
    input  logic [8*W-1:0]          row_data_in,
    output logic                    busy,
    output logic                    frame_done,
    pixel_frame_sequencer_if.master out_if
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(H - 1);

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               load;
    logic               accept;

    // State, phase counter and current row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
        end
    end

    // Next state and strobes; the counter restarts at zero on every transition.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        erase      = 1'b0;
        expose     = 1'b0;
        convert    = 1'b0;
        ramp_count = 8'd0;
        read_en    = '0;
        load       = 1'b0;
        frame_done = 1'b0;
        busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ERASE;
                    cnt_d   = 8'd0;
                end
            end
            ST_ERASE: begin
                erase = 1'b1;
                if (cnt_q == last_cycle(C_ERASE)) begin
                    state_d = ST_EXPOSE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_EXPOSE: begin
                expose = 1'b1;
                if (cnt_q == last_cycle(C_EXPOSE)) begin
                    state_d = ST_CONVERT;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_CONVERT: begin
                convert    = 1'b1;
                ramp_count = cnt_q;
                if (cnt_q == last_cycle(C_CONVERT)) begin
                    state_d = ST_READ;
                    cnt_d   = 8'd0;
                    row_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_READ: begin
                read_en = H'(1) << row_q;
                if (cnt_q == last_cycle(C_READ)) begin
                    load    = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WAIT: begin
                if (accept) begin
                    cnt_d = 8'd0;
                    if (row_q == LAST_ROW) begin
                        frame_done = 1'b1;
                        row_d      = '0;
                        state_d    = continuous ? ST_ERASE : ST_IDLE;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = ST_READ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
                row_d   = '0;
            end
        endcase
    end

    pixel_row_buffer #(
        .H (H),
        .W (W)
    ) u_row_buffer (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load),
        .data_i   (row_data_in),
        .row_i    (row_q),
        .accept_o (accept),
        .out_if   (out_if)
    );

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_frame_sequencer
//  Purpose  : Scoreboard bench for pixel_frame_sequencer (H=4, W=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_frame_sequencer;

    localparam int H  = 4;
    localparam int W  = 4;
    localparam int CE = 5;
    localparam int CX = 255;
    localparam int CC = 255;
    localparam int CR = 5;
    localparam int FRAME_BUDGET = 2000;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           continuous;
    logic           out_ready;
    logic           erase, expose, convert, busy, frame_done;
    logic [7:0]     ramp_count;
    logic [H-1:0]   read_en;
    logic [8*W-1:0] row_data_in;
    logic [7:0]     salt;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_count = 0;

    typedef struct {
        logic [1:0]  row;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    pixel_frame_sequencer_if #(.H(H), .W(W)) out_if ();
    assign out_if.out_ready = out_ready;

    pixel_frame_sequencer #(
        .H(H), .W(W), .C_ERASE(CE), .C_EXPOSE(CX), .C_CONVERT(CC), .C_READ(CR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .continuous  (continuous),
        .erase       (erase),
        .expose      (expose),
        .convert     (convert),
        .ramp_count  (ramp_count),
        .read_en     (read_en),
        .row_data_in (row_data_in),
        .busy        (busy),
        .frame_done  (frame_done),
        .out_if      (out_if)
    );

    always #5 clk = ~clk;

    // Pixel column k of row r reads as 16*r + k, offset by a per-frame salt.
    function automatic logic [31:0] row_pattern(input int r, input logic [7:0] s);
        logic [31:0] v;
        v = '0;
        for (int c = 0; c < W; c++) v[8*c +: 8] = 8'(16 * r + c) + s;
        return v;
    endfunction

    // Pixel array model: only the selected row drives the column bus.
    always_comb begin
        row_data_in = '0;
        for (int r = 0; r < H; r++)
            if (read_en[r]) row_data_in = row_pattern(r, salt);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] s);
        for (int r = 0; r < H; r++) sb.push_back('{row: 2'(r), data: row_pattern(r, s)});
    endtask

    task automatic wait_for(input int sel, input int budget, input string name);
        bit hit;
        int n;
        hit = 1'b0;
        n   = 0;
        while (n < budget) begin
            case (sel)
                0: hit = frame_done;
                1: hit = !busy;
                2: hit = read_en[2];
                3: hit = convert && (ramp_count == 8'd100);
                4: hit = out_if.out_valid;
                5: hit = expose;
                default: hit = 1'b0;
            endcase
            if (hit) break;
            cyc();
            n++;
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL timeout %s: waited %0d cycles, required event not seen", name, budget);
        end
    endtask

    // Monitor: scoreboard pops on accept, hold stability, phase lengths, exclusivity.
    initial begin
        int er, ex, cv, rd;
        logic hold;
        logic [31:0] hd;
        logic [1:0] hr;
        exp_t e;
        er = 0; ex = 0; cv = 0; rd = 0; hold = 1'b0; hd = '0; hr = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                er = 0; ex = 0; cv = 0; rd = 0; hold = 1'b0;
                continue;
            end
            if (frame_done) fd_count++;
            chk("exclusive_strobes",
                64'(((32'(erase) + 32'(expose) + 32'(convert) + $countones(read_en)) <= 1) ? 1 : 0), 64'd1);
            if (erase) er++;
            else if (er != 0) begin chk("erase_len", 64'(er), 64'(CE)); er = 0; end
            if (expose) ex++;
            else if (ex != 0) begin chk("expose_len", 64'(ex), 64'(CX)); ex = 0; end
            if (read_en != '0) rd++;
            else if (rd != 0) begin chk("read_len", 64'(rd), 64'(CR)); rd = 0; end
            if (convert) begin
                chk("ramp_value", 64'(ramp_count), 64'(cv));
                cv++;
            end else begin
                if (cv != 0) begin chk("convert_len", 64'(cv), 64'(CC)); cv = 0; end
                chk("ramp_idle", 64'(ramp_count), 64'd0);
            end
            if (hold) begin
                chk("hold_valid", 64'(out_if.out_valid), 64'd1);
                chk("hold_data", 64'(out_if.out_data), 64'(hd));
                chk("hold_row", 64'(out_if.out_row), 64'(hr));
            end
            hold = out_if.out_valid && !out_ready;
            hd   = out_if.out_data;
            hr   = out_if.out_row;
            if (out_if.out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_row: got row %0d data %0h, expected no row", out_if.out_row, out_if.out_data);
                end else begin
                    e = sb.pop_front();
                    chk("sb_row", 64'(out_if.out_row), 64'(e.row));
                    chk("sb_data", 64'(out_if.out_data), 64'(e.data));
                end
            end
        end
    end

    // Stimulus
    initial begin
        reset = 1'b0; start = 1'b0; continuous = 1'b0; out_ready = 1'b1; salt = 8'h00;
        repeat (3) cyc();

        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_erase", 64'(erase), 64'd0);
        chk("rst_read_en", 64'(read_en), 64'd0);
        chk("rst_ramp", 64'(ramp_count), 64'd0);
        chk("rst_valid", 64'(out_if.out_valid), 64'd0);
        chk("rst_data", 64'(out_if.out_data), 64'd0);
        chk("rst_row", 64'(out_if.out_row), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);

        // Single frame, start on the first edge after reset release
        reset = 1'b1; start = 1'b1;
        push_frame(salt);
        cyc();
        chk("first_start_erase", 64'(erase), 64'd1);
        chk("first_start_busy", 64'(busy), 64'd1);
        start = 1'b0;
        wait_for(0, FRAME_BUDGET, "frame1_done");
        cyc();
        chk("frame1_idle", 64'(busy), 64'd0);
        chk("frame1_done_count", 64'(fd_count), 64'd1);
        chk("frame1_sb_empty", 64'(sb.size()), 64'd0);

        // Backpressure on row 2 for 20 cycles
        salt = 8'h05;
        push_frame(salt);
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_for(2, FRAME_BUDGET, "row2_read");
        out_ready = 1'b0;
        wait_for(4, 20, "row2_valid");
        repeat (20) begin
            chk("stall_read_en", 64'(read_en), 64'd0);
            chk("stall_valid", 64'(out_if.out_valid), 64'd1);
            chk("stall_row", 64'(out_if.out_row), 64'd2);
            cyc();
        end
        out_ready = 1'b1;
        wait_for(0, FRAME_BUDGET, "stall_frame_done");
        cyc();
        chk("stall_idle", 64'(busy), 64'd0);
        chk("stall_done_count", 64'(fd_count), 64'd2);

        // Continuous: second frame starts right after frame_done
        salt = 8'h20;
        push_frame(salt);
        push_frame(salt);
        continuous = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_for(0, FRAME_BUDGET, "cont_f1_done");
        cyc();
        chk("cont_erase_next", 64'(erase), 64'd1);
        chk("cont_busy", 64'(busy), 64'd1);
        continuous = 1'b0;
        wait_for(0, FRAME_BUDGET, "cont_f2_done");
        cyc();
        chk("cont_idle", 64'(busy), 64'd0);
        chk("cont_done_count", 64'(fd_count), 64'd4);

        // Reset in the middle of CONVERT
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_for(3, FRAME_BUDGET, "ramp_100");
        reset = 1'b0;
        #1;
        chk("midrst_convert", 64'(convert), 64'd0);
        chk("midrst_ramp", 64'(ramp_count), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_valid", 64'(out_if.out_valid), 64'd0);
        chk("midrst_read_en", 64'(read_en), 64'd0);
        repeat (3) cyc();
        reset = 1'b1;
        repeat (400) cyc();
        chk("midrst_idle", 64'(busy), 64'd0);
        chk("midrst_no_done", 64'(fd_count), 64'd4);

        // Start pulsed during EXPOSE is ignored
        salt = 8'h33;
        push_frame(salt);
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_for(5, 100, "expose_seen");
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("expose_start_ignored", 64'(expose), 64'd1);
        wait_for(0, FRAME_BUDGET, "expose_frame_done");
        cyc();
        repeat (50) cyc();
        chk("single_frame_idle", 64'(busy), 64'd0);
        chk("single_frame_count", 64'(fd_count), 64'd5);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
